noc_inject_ni: RTL

- Network-interface injection stage between a node's `dataout_buf_N` traffic source and the router's local input port.
- Accepts the source's 20-bit flit stream. That stream has no stall input, so valid words cannot be held back once emitted.
- Discards null (all-zero) padding words and buffers real flits in a first-word-fall-through FIFO.
- Presents flits to the router with a valid/ready handshake, and throttles the source through its `enable` input so the FIFO never overflows in normal operation.

---
 rtl/noc_inject_ni.sv | 113 +++++++++++
 1 files changed

// File: rtl/noc_inject_ni.sv
// noc_inject_ni: null-filtering first-word-fall-through injection buffer between a flit source and a router local port.
// Build option NOC_INJ_SEQ_TAG_EN stamps a 4-bit injection sequence number into bits [19:16] of every accepted flit.
module noc_inject_ni #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int SKID  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inj_go,
  output logic        src_enable,
  input  logic [19:0] src_data,
  input  logic        src_valid,
  output logic [19:0] flit_out,
  output logic        flit_valid,
  input  logic        flit_ready,
  output logic [7:0]  inj_cnt,
  output logic [7:0]  drop_cnt,
  output logic        overflow,
  output logic [AW:0] fifo_count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] SKID_C  = (AW+1)'(SKID);

  logic [19:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          src_en_q, src_en_d;
  logic [7:0]    inj_cnt_q, inj_cnt_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          ovf_q, ovf_d;

  logic          push_req, push, pop, drop;
  logic [19:0]   wr_data;

`ifdef NOC_INJ_SEQ_TAG_EN
  logic [3:0]    seq_q, seq_d;
`endif

  always_comb begin
    // NOTE: every signal gets a value on every path first, so no latch can be inferred.
    push_req = src_valid && (src_data != 20'h00000);
    pop      = (count_q != '0) && flit_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push     = push_req && ((count_q != DEPTH_C) || pop);
    drop     = push_req && !push;

    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);

    // Throttle on the post-update count so SKID words in flight always have room.
    src_en_d = inj_go && ((DEPTH_C - count_d) > SKID_C);

    inj_cnt_d  = (pop  && (inj_cnt_q  != 8'hFF)) ? inj_cnt_q  + 8'd1 : inj_cnt_q;
    drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    ovf_d      = ovf_q | drop;

`ifdef NOC_INJ_SEQ_TAG_EN
    wr_data = {seq_q, src_data[15:0]};
    seq_d   = push ? seq_q + 4'd1 : seq_q;
`else
    wr_data = src_data;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      src_en_q   <= 1'b0;
      inj_cnt_q  <= 8'h00;
      drop_cnt_q <= 8'h00;
      ovf_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      src_en_q   <= src_en_d;
      inj_cnt_q  <= inj_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef NOC_INJ_SEQ_TAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) seq_q <= 4'd0;
    else      seq_q <= seq_d;
  end
`endif

  // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign flit_valid = (count_q != '0);
  assign flit_out   = flit_valid ? mem_q[rd_ptr_q] : 20'h00000;
  assign src_enable = src_en_q;
  assign inj_cnt    = inj_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule
